// File: rtl/dvp_rgb565_capture.sv
// OV5640 DVP receiver: discards settling frames, packs byte pairs into RGB565,
// expands to RGB888 and tags each pixel with position, frame markers and error pulses.
module dvp_rgb565_capture #(
    parameter int H_RES       = 1280,
    parameter int V_RES       = 720,
    parameter int SKIP_FRAMES = 10,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_vsync,
    input  logic        I_href,
    input  logic [7:0]  I_data,
    output logic        O_pix_valid,
    output logic [15:0] O_pix_data,
    output logic [7:0]  O_data_r,
    output logic [7:0]  O_data_g,
    output logic [7:0]  O_data_b,
    output logic [11:0] O_x,
    output logic [11:0] O_y,
    output logic        O_sof,
    output logic        O_eol,
    output logic        O_eof,
    output logic [15:0] O_frame_cnt,
    output logic        O_line_err,
    output logic        O_frame_err,
    output logic        O_ready
);
    typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_SKIP = 2'd1, ST_FRAME = 2'd2} state_t;

    localparam logic [11:0] H_RES_C = 12'(H_RES);
    localparam logic [11:0] V_RES_C = 12'(V_RES);
    localparam logic [11:0] H_LAST  = 12'(H_RES - 1);
    localparam logic [11:0] V_LAST  = 12'(V_RES - 1);
    localparam logic [15:0] SKIP_C  = 16'(SKIP_FRAMES);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic        vs1_q, vs_prev_q, hs1_q, hs_prev_q;
    logic [7:0]  d1_q;
    logic        blank_start_s, href_fall_s;
    logic [11:0] y_line_s;

    state_t      state_q, state_d;
    logic [15:0] skip_cnt_q, skip_cnt_d, frame_cnt_q, frame_cnt_d;
    logic        ready_q, ready_d, phase_q, phase_d, abort_q, abort_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] x_q, x_d, y_q, y_d;

    logic        s2_valid_q, s2_valid_d, s2_lerr_q, s2_lerr_d, s2_ferr_q, s2_ferr_d;
    logic [15:0] s2_pix_q, s2_pix_d;
    logic [11:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;

    logic        pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [7:0]  data_r_q, data_r_d, data_g_q, data_g_d, data_b_q, data_b_d;
    logic [11:0] x_out_q, x_out_d, y_out_q, y_out_d;

    // Stage-1 bus capture plus one cycle of history for edge detection
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs1_q     <= ~VS_POL;
            vs_prev_q <= ~VS_POL;
            hs1_q     <= 1'b0;
            hs_prev_q <= 1'b0;
            d1_q      <= 8'h00;
        end else begin
            vs1_q     <= I_vsync;
            vs_prev_q <= vs1_q;
            hs1_q     <= I_href;
            hs_prev_q <= hs1_q;
            d1_q      <= I_data;
        end
    end

    assign blank_start_s = (vs1_q == VS_POL) && (vs_prev_q != VS_POL);
    assign href_fall_s   = hs_prev_q && !hs1_q;

    // Frame FSM, byte packing, position counters and line/frame checks
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        ready_d     = ready_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        x_d         = x_q;
        y_d         = y_q;
        abort_d     = abort_q;
        s2_valid_d  = 1'b0;
        s2_pix_d    = s2_pix_q;
        s2_x_d      = s2_x_q;
        s2_y_d      = s2_y_q;
        s2_lerr_d   = 1'b0;
        s2_ferr_d   = 1'b0;
        y_line_s    = y_q;
        case (state_q)
            ST_SYNC: begin
                if (blank_start_s) begin
                    if (SKIP_C == 16'd0) begin
                        state_d = ST_FRAME;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_SKIP: begin
                if (blank_start_s) begin
                    skip_cnt_d = skip_cnt_q + 16'd1;
                    if ((skip_cnt_q + 16'd1) == SKIP_C) begin
                        state_d = ST_FRAME;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end else begin
                    state_d = ST_SKIP;
                end
            end
            ST_FRAME: begin
                if (hs1_q && !abort_q) begin
                    if (!phase_q) begin
                        hi_d    = d1_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        x_d     = (x_q == CNT_MAX) ? x_q : x_q + 12'd1;
                        if ((x_q < H_RES_C) && (y_q < V_RES_C)) begin
                            s2_valid_d = 1'b1;
                            s2_pix_d   = {hi_q, d1_q};
                            s2_x_d     = x_q;
                            s2_y_d     = y_q;
                        end else begin
                            s2_valid_d = 1'b0;
                        end
                    end
                end else begin
                    // An aborted line stays ignored until href drops
                    phase_d = 1'b0;
                    abort_d = abort_q && hs1_q;
                end
                if (href_fall_s && !abort_q) begin
                    y_line_s  = (y_q == CNT_MAX) ? y_q : y_q + 12'd1;
                    s2_lerr_d = phase_q || (x_q != H_RES_C);
                    x_d       = 12'd0;
                    y_d       = y_line_s;
                    phase_d   = 1'b0;
                end else begin
                    y_line_s = y_q;
                end
                // Frame check counts a line whose href fell in this same cycle
                if (blank_start_s) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    x_d         = 12'd0;
                    y_d         = 12'd0;
                    phase_d     = 1'b0;
                    if (hs1_q) begin
                        s2_valid_d = 1'b0;
                        s2_lerr_d  = 1'b1;
                        s2_ferr_d  = 1'b1;
                        abort_d    = 1'b1;
                    end else begin
                        s2_ferr_d = (y_line_s != V_RES_C);
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Output stage: RGB888 expansion and markers registered with the valid strobe
    always_comb begin
        pix_valid_d = s2_valid_q;
        pix_data_d  = s2_pix_q;
        data_r_d    = {s2_pix_q[15:11], s2_pix_q[15:13]};
        data_g_d    = {s2_pix_q[10:5], s2_pix_q[10:9]};
        data_b_d    = {s2_pix_q[4:0], s2_pix_q[4:2]};
        x_out_d     = s2_x_q;
        y_out_d     = s2_y_q;
        sof_d       = s2_valid_q && (s2_x_q == 12'd0) && (s2_y_q == 12'd0);
        eol_d       = s2_valid_q && (s2_x_q == H_LAST);
        eof_d       = s2_valid_q && (s2_x_q == H_LAST) && (s2_y_q == V_LAST);
        line_err_d  = s2_lerr_q;
        frame_err_d = s2_ferr_q;
    end

    // State, packing, pipeline and output registers
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_SYNC;
            skip_cnt_q  <= 16'd0;
            ready_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'h00;
            x_q         <= 12'd0;
            y_q         <= 12'd0;
            abort_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_pix_q    <= 16'h0000;
            s2_x_q      <= 12'd0;
            s2_y_q      <= 12'd0;
            s2_lerr_q   <= 1'b0;
            s2_ferr_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 16'h0000;
            data_r_q    <= 8'h00;
            data_g_q    <= 8'h00;
            data_b_q    <= 8'h00;
            x_out_q     <= 12'd0;
            y_out_q     <= 12'd0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            ready_q     <= ready_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            abort_q     <= abort_d;
            s2_valid_q  <= s2_valid_d;
            s2_pix_q    <= s2_pix_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            s2_lerr_q   <= s2_lerr_d;
            s2_ferr_q   <= s2_ferr_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            data_r_q    <= data_r_d;
            data_g_q    <= data_g_d;
            data_b_q    <= data_b_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign O_pix_valid = pix_valid_q;
    assign O_pix_data  = pix_data_q;
    assign O_data_r    = data_r_q;
    assign O_data_g    = data_g_q;
    assign O_data_b    = data_b_q;
    assign O_x         = x_out_q;
    assign O_y         = y_out_q;
    assign O_sof       = sof_q;
    assign O_eol       = eol_q;
    assign O_eof       = eof_q;
    assign O_frame_cnt = frame_cnt_q;
    assign O_line_err  = line_err_q;
    assign O_frame_err = frame_err_q;
    assign O_ready     = ready_q;
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture: three instances (SKIP_FRAMES 0/1/2) share one
// camera bus; only the selected one is out of reset. Expected pixels go through a queue.
module tb_dvp_rgb565_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        vsync, href;
    logic [7:0]  data;
    logic [2:0]  rst_n_v;
    logic [1:0]  sel;

    logic [2:0]        o_valid, o_sof, o_eol, o_eof, o_lerr, o_ferr, o_ready;
    logic [2:0][15:0]  o_pix, o_fcnt;
    logic [2:0][7:0]   o_r, o_g, o_b;
    logic [2:0][11:0]  o_x, o_y;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dvp_rgb565_capture #(.H_RES(4), .V_RES(2), .SKIP_FRAMES(g), .VS_POL(1'b1)) u_dut (
            .I_clk(clk), .I_rst_n(rst_n_v[g]), .I_vsync(vsync), .I_href(href), .I_data(data),
            .O_pix_valid(o_valid[g]), .O_pix_data(o_pix[g]), .O_data_r(o_r[g]),
            .O_data_g(o_g[g]), .O_data_b(o_b[g]), .O_x(o_x[g]), .O_y(o_y[g]),
            .O_sof(o_sof[g]), .O_eol(o_eol[g]), .O_eof(o_eof[g]), .O_frame_cnt(o_fcnt[g]),
            .O_line_err(o_lerr[g]), .O_frame_err(o_ferr[g]), .O_ready(o_ready[g])
        );
    end

    typedef struct {
        logic [15:0] pix;
        logic [23:0] rgb;
        logic [11:0] x, y;
        logic [2:0]  mk;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0, n_fail = 0;
    int   n_lerr = 0, n_ferr = 0, n_both = 0, n_valid = 0;
    int   cyc_cnt = 0;
    int   l0, f0, b0, v0;

    logic [7:0]  pat [8]     = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    logic [15:0] pix_tab [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    logic [23:0] rgb_tab [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Monitor: pop the scoreboard on every valid pixel, tally error pulses
    always @(negedge clk) begin
        if (o_lerr[sel]) n_lerr++;
        if (o_ferr[sel]) n_ferr++;
        if (o_lerr[sel] && o_ferr[sel]) n_both++;
        if (!o_valid[sel]) begin
            check("marker_without_valid", {o_sof[sel], o_eol[sel], o_eof[sel]}, 3'b000);
        end else begin
            n_valid++;
            check("pixel_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pix_data", o_pix[sel], mon_e.pix);
                check("rgb888", {o_r[sel], o_g[sel], o_b[sel]}, mon_e.rgb);
                check("pos_xy", {o_x[sel], o_y[sel]}, {mon_e.x, mon_e.y});
                check("sof_eol_eof", {o_sof[sel], o_eol[sel], o_eof[sel]}, mon_e.mk);
                check("latency", cyc_cnt, mon_e.cyc);
            end
        end
    end

    task automatic push_pix(input int p, input int yexp);
        exp_t e;
        e.pix = pix_tab[p % 4];
        e.rgb = rgb_tab[p % 4];
        e.x   = 12'(p);
        e.y   = 12'(yexp);
        e.mk  = {(p == 0 && yexp == 0), (p == 3), (p == 3 && yexp == 1)};
        e.cyc = cyc_cnt + 3;
        sb.push_back(e);
    endtask

    task automatic send_line(input int nbytes, input int yexp, input bit cap);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            href = 1'b1;
            data = pat[i % 8];
            if (cap && (i % 2 == 1) && (i / 2 < 4) && (yexp < 2)) push_pix(i / 2, yexp);
        end
        @(posedge clk); #1;
        href = 1'b0;
        data = 8'h00;
        repeat (3) @(posedge clk);
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic frame(input bit cap);
        send_line(8, 0, cap);
        send_line(8, 1, cap);
    endtask

    task automatic snap();
        l0 = n_lerr; f0 = n_ferr; b0 = n_both; v0 = n_valid;
    endtask

    task automatic settle_checks(input string tag, input int dl, input int df, input int dv);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check({tag, "_queue_drained"}, sb.size(), 0);
        check({tag, "_line_err_count"}, n_lerr - l0, dl);
        check({tag, "_frame_err_count"}, n_ferr - f0, df);
        check({tag, "_pixel_count"}, n_valid - v0, dv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 2'd0; rst_n_v = 3'b000;
        vsync = 1'b0; href = 1'b0; data = 8'h00;

        // Reset with random bus activity
        repeat (12) begin
            @(posedge clk); #1;
            vsync = 1'($urandom_range(0, 1));
            href  = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            @(negedge clk);
            check("reset_outputs_zero",
                  {o_valid[0], o_pix[0], o_r[0], o_g[0], o_b[0], o_x[0], o_y[0], o_sof[0],
                   o_eol[0], o_eof[0], o_fcnt[0], o_lerr[0], o_ferr[0], o_ready[0]}, 0);
        end
        @(posedge clk); #1;
        vsync = 1'b0; href = 1'b0; data = 8'h00; rst_n_v[0] = 1'b1;
        snap();
        repeat (20) begin
            @(posedge clk); #1;
            href = 1'($urandom_range(0, 1));
            data = 8'($urandom);
        end
        @(posedge clk); #1 href = 1'b0;
        settle_checks("sync_idle", 0, 0, 0);
        check("sync_ready", o_ready[0], 1'b0);

        // Clean frame
        snap();
        vsync_pulse();
        check("clean_ready", o_ready[0], 1'b1);
        frame(1'b1);
        vsync_pulse();
        settle_checks("clean", 0, 0, 8);
        check("clean_frame_cnt", o_fcnt[0], 16'd1);

        // Short / odd line, then a normal line
        snap();
        send_line(5, 0, 1'b1);
        send_line(8, 1, 1'b1);
        vsync_pulse();
        settle_checks("odd_line", 1, 0, 6);
        check("odd_frame_cnt", o_fcnt[0], 16'd2);

        // Overlong line, then vsync in the middle of the next line
        snap();
        send_line(12, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            href = 1'b1;
            data = pat[i];
            if (i == 1 || i == 3) push_pix(i / 2, 1);
            if (i == 4) vsync = 1'b1;
        end
        @(posedge clk); #1 href = 1'b0;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        settle_checks("overlong_midline", 2, 1, 6);
        check("midline_same_cycle", n_both - b0, 1);
        check("midline_frame_cnt", o_fcnt[0], 16'd3);
        snap();
        frame(1'b1);
        vsync_pulse();
        settle_checks("after_abort", 0, 0, 8);
        check("after_abort_frame_cnt", o_fcnt[0], 16'd4);

        // Skip frames (SKIP_FRAMES=2)
        @(posedge clk); #1;
        rst_n_v = 3'b100; sel = 2'd2;
        repeat (3) @(posedge clk);
        snap();
        for (int f = 1; f <= 4; f++) begin
            vsync_pulse();
            @(negedge clk);
            check($sformatf("skip_ready_v%0d", f), o_ready[2], (f >= 3));
            if (f == 4) check("skip_frame_cnt_v4", o_fcnt[2], 16'd1);
            frame(f >= 3);
        end
        settle_checks("skip", 0, 0, 16);

        // Reset in the middle of a captured frame (SKIP_FRAMES=1)
        @(posedge clk); #1;
        rst_n_v = 3'b010; sel = 2'd1;
        repeat (3) @(posedge clk);
        vsync_pulse();
        frame(1'b0);
        vsync_pulse();
        frame(1'b1);
        vsync_pulse();
        @(negedge clk);
        check("pre_reset_frame_cnt", o_fcnt[1], 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            href = 1'b1;
            data = pat[i];
            if (i == 1) push_pix(0, 0);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n_v[1] = 1'b0;
        href = 1'b0;
        #1;
        check("midframe_reset_zero",
              {o_valid[1], o_pix[1], o_r[1], o_g[1], o_b[1], o_x[1], o_y[1], o_sof[1],
               o_eol[1], o_eof[1], o_fcnt[1], o_lerr[1], o_ferr[1], o_ready[1]}, 0);
        check("midframe_reset_queue", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n_v[1] = 1'b1;
        snap();
        vsync_pulse();
        @(negedge clk);
        check("rerun_ready_v1", o_ready[1], 1'b0);
        frame(1'b0);
        vsync_pulse();
        @(negedge clk);
        check("rerun_ready_v2", o_ready[1], 1'b1);
        check("rerun_frame_cnt_v2", o_fcnt[1], 16'd0);
        frame(1'b1);
        vsync_pulse();
        settle_checks("rerun", 0, 0, 8);
        check("rerun_frame_cnt_v3", o_fcnt[1], 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dvp_rgb565_capture.md
Name: dvp_rgb565_capture

Overview:
Receive side of the OV5640 DVP camera bus (vsync/href/8-bit data), clocked by the camera pixel clock.
- Discards the first SKIP_FRAMES frames after reset while the sensor's auto-exposure settles.
- Packs byte pairs into RGB565 pixels, expands each to RGB888, and emits a valid-qualified pixel stream with x/y position, frame markers and error pulses.
- Feeds the frame buffer and CV pipeline that later replace the HDMI test pattern.

Parameters:
H_RES, 1280, active pixels per line
V_RES, 720, active lines per frame
SKIP_FRAMES, 10, complete frames discarded after reset (0 = none)
VS_POL, 1, vsync level that marks vertical blanking (1 = active high)

Ports:
I_clk  input  1  camera pixel clock (cmos_pclk); all logic on rising edge
I_rst_n  input  1  asynchronous reset, active low
I_vsync  input  1  camera vsync
I_href  input  1  camera href, byte valid
I_data  input  8  camera data byte
O_pix_valid  output  1  one-cycle strobe, pixel outputs valid
O_pix_data  output  16  RGB565 pixel, first byte of pair in [15:8]
O_data_r  output  8  expanded red
O_data_g  output  8  expanded green
O_data_b  output  8  expanded blue
O_x  output  12  column of current pixel, 0..H_RES-1
O_y  output  12  row of current pixel, 0..V_RES-1
O_sof  output  1  with O_pix_valid at x=0,y=0
O_eol  output  1  with O_pix_valid at x=H_RES-1
O_eof  output  1  with O_pix_valid at x=H_RES-1,y=V_RES-1
O_frame_cnt  output  16  frames ended in FRAME state, wraps 65535->0
O_line_err  output  1  one-cycle error pulse, line length
O_frame_err  output  1  one-cycle error pulse, frame length
O_ready  output  1  high once skipping is finished

Behaviour:
Reset
- Every output is 0 while I_rst_n is low.
- FSM enters SYNC; all counters clear.
- Reset asserted mid-frame aborts the frame; the skip sequence restarts from 0 after release.

Input stage
- I_vsync, I_href and I_data are registered once (stage 1).
- A vsync edge is detected from stage 1 against its previous value.
- "Blank start" = stage-1 vsync goes to the VS_POL level.

FSM
- SYNC: ignore everything until the first blank start. Then go to SKIP if SKIP_FRAMES>0, else FRAME.
- SKIP: each blank start increments skip_cnt. At skip_cnt==SKIP_FRAMES go to FRAME and set O_ready=1. O_ready stays 1 until reset.
- FRAME: capture active. Each blank start ends the frame and the FSM stays in FRAME.

Byte packing (FRAME, stage-1 href=1)
- phase toggles every byte. phase 0 stores the high byte; phase 1 completes the pixel.
- phase clears when href is low.
- Latency: a second byte present at I_clk edge n produces O_pix_valid=1 for exactly the cycle after edge n+2 (2-cycle latency). All pixel outputs are registered together with O_pix_valid.
- RGB888 expansion: R={p[15:11],p[15:13]}, G={p[10:5],p[10:9]}, B={p[4:0],p[4:2]}.

Position counters
- x increments per pixel and clears at the href falling edge.
- y increments at each href falling edge that had at least one byte, and clears at blank start.
- Pixels with x>=H_RES or lines with y>=V_RES are dropped: no O_pix_valid, counters saturate.

Errors
- Line check at the href falling edge:
  - Odd byte count: the trailing byte is discarded.
  - Pixel count != H_RES, or odd byte count: O_line_err pulses 2 cycles after the falling edge.
- Frame check at blank start in FRAME:
  - Line count != V_RES: O_frame_err pulses.
  - O_frame_cnt increments regardless of the check result.
- Blank start while href is high (vsync mid-line):
  - The line is aborted.
  - O_line_err and O_frame_err pulse in the same cycle.
  - x, y and phase clear.
- Simultaneous href fall and blank start: the line check is evaluated first, then the counters clear. Each error pulses at most once.
- Markers: O_sof, O_eol and O_eof never assert without O_pix_valid. O_eof implies O_eol.

Test Plan:
Common setup: H_RES=4, V_RES=2, VS_POL=1, SKIP_FRAMES=0 unless stated.
1. Reset
   - Stimulus: hold I_rst_n=0 with random bus activity.
   - Required: all outputs 0. After release with no vsync edge, O_pix_valid never asserts.
2. Clean frame
   - Stimulus: vsync pulse, then 2 lines of 8 bytes each, pixel bytes F8,00 / 07,E0 / 00,1F / FF,FF, then vsync.
   - Required, per line: pixels F800, 07E0, 001F, FFFF, giving RGB (FF,00,00), (00,FF,00), (00,00,FF), (FF,FF,FF).
   - Required: O_sof at first pixel; O_eol at x=3; O_eof at y=1,x=3; O_frame_cnt=1; no error pulses.
   - Required latency: 2 cycles from second byte to O_pix_valid.
3. Skip frames
   - Stimulus: SKIP_FRAMES=2, four clean frames.
   - Required: O_ready rises at the 3rd vsync. Only frames 3 and 4 produce pixels. O_frame_cnt=1 after the 4th vsync.
4. Short/odd line
   - Stimulus: line of 5 bytes.
   - Required: 2 pixels output, trailing byte dropped, O_line_err pulses once. Next line captures normally from x=0.
5. Overlong and mid-line vsync
   - Stimulus: line of 12 bytes, then a vsync during the following line.
   - Required: first line outputs only x=0..3 and O_line_err pulses. Vsync mid-line gives one O_line_err and one O_frame_err in the same cycle, and x/y restart at 0 in the next frame.
6. Reset mid-frame
   - Stimulus: SKIP_FRAMES=1; assert I_rst_n low during line 1 of a captured frame.
   - Required: outputs clear immediately. After release, the first frame is skipped again and O_frame_cnt restarts from 0.
